load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: ADDR_WIDTH, 32, byte-address width on core and memory sides.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  sole clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  core access request.
- req_ready  out  1  unit idle, can accept a request.
- req_write  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I width/sign code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores.
- resp_err  out  1  valid with resp_valid; access faulted.
- mem_req  out  1  memory request.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_we  out  1  write strobe.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_WIDTH  word-aligned address, bits[1:0]=0.
- mem_wdata  out  32  lane-shifted store data.
- mem_rvalid  in  1  read data valid, one per granted load.
- mem_rdata  in  32  read word.

Function
REQ-003 SHALL use FSM IDLE, REQ, WAIT, RESP; req_ready=1 only in IDLE.
REQ-004 SHALL capture all req_* fields on req_valid&&req_ready; IDLE->REQ; later req_* changes ignored.
REQ-005 In REQ, mem_req, mem_we, mem_be, mem_addr and mem_wdata SHALL be driven from registers and held stable until mem_gnt.
REQ-006 On mem_gnt: a load SHALL go to WAIT; a store SHALL go to RESP.
REQ-007 WAIT->RESP on mem_rvalid; mem_rdata SHALL be latched that cycle; mem_rvalid outside WAIT SHALL be ignored.
REQ-008 RESP SHALL assert resp_valid for exactly one cycle, then go to IDLE.
REQ-009 Minimum latency, with accept in cycle 0: store with mem_gnt in cycle 1 gives resp_valid in cycle 2; load with mem_gnt in cycle 1 and mem_rvalid in cycle 2 gives resp_valid in cycle 3.
REQ-010 Lanes: byte uses be=0001<<addr[1:0] and wdata byte replicated x4; half uses be=0011<<addr[1:0] and wdata half replicated x2; word uses be=1111.
REQ-011 Loads SHALL select the addressed byte/half, sign-extend for LB/LH and zero-extend for LBU/LHU.
REQ-012 Illegal funct3 (011, 11x; any funct3 >=011 on store) SHALL skip the memory and go IDLE->RESP with resp_err=1; mem_req is never asserted for it.
REQ-013 Misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0) SHALL behave as in REQ-021/022.
REQ-014 A request presented in the same cycle as resp_valid SHALL not be accepted (req_ready=0); it is accepted the next cycle.

Reset
REQ-015 rst_n=0 at a clock edge SHALL force IDLE in any state, including REQ/WAIT mid-transaction; the outstanding access is abandoned with no response.
REQ-016 Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-017 A mem_rvalid arriving after reset for an abandoned load SHALL be ignored (state is IDLE).

Configuration
REQ-018 Macro LSU_MISALIGN_SPLIT_EN SHALL select misaligned-access handling.
REQ-019 Sub-states REQ2 and WAIT2 SHALL be added only when LSU_MISALIGN_SPLIT_EN is defined.
REQ-020 Only one branch of REQ-021/022 SHALL be compiled in; resp_err is never set for misalignment when LSU_MISALIGN_SPLIT_EN is defined.
REQ-021 Defined: a misaligned access SHALL split into two word accesses, to floor(addr) and floor(addr)+4; byte enables and data are split across both; loads merge both words before extension; resp_valid follows the second completion.
REQ-022 Undefined: a misaligned access SHALL complete without memory traffic; resp_valid arrives in the cycle after accept with resp_err=1 and resp_rdata=0.

Verification
REQ-023 Store SB addr=0x103 wdata=0x000000A5, mem_gnt immediate -> mem_addr=0x100, mem_be=1000, mem_wdata=0xA5A5A5A5, resp_valid in cycle 2.
REQ-024 Load LH addr=0x202, mem_rdata=0x8001_1234 -> resp_rdata=0xFFFF8001; with LHU -> 0x00008001.
REQ-025 Load LW, mem_gnt held low 5 cycles, then mem_rvalid 3 cycles later -> mem_* fields stable throughout; single resp_valid; rdata equals mem_rdata.
REQ-026 LW addr=0x101: without macro -> no mem_req, resp_err=1; with macro -> accesses 0x100 (be=1110) and 0x104 (be=0001); words 0x44332211 and 0x88776655 -> resp_rdata=0x55443322.
REQ-027 rst_n low while in WAIT, then stray mem_rvalid -> no resp_valid, req_ready=1, all REQ-016 values.
REQ-028 funct3=011 load -> resp_err=1 one cycle after accept; mem_req never asserted.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, lane steering, load extension.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two word accesses.

module load_store_unit #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic                  mem_req,
   input  logic                  mem_gnt,
   output logic                  mem_we,
   output logic [3:0]            mem_be,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_rvalid,
   input  logic [31:0]           mem_rdata
);

   // state   | meaning
   // IDLE    | ready for a request
   // REQ     | first (or only) memory request held until granted
   // WAIT    | load granted, waiting for read data
   // RESP    | one-cycle response pulse
   // REQ2    | second half of a split access held until granted
   // WAIT2   | second half of a split load waiting for read data
   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_RESP
`ifdef LSU_MISALIGN_SPLIT_EN
      , S_REQ2, S_WAIT2
`endif
   } state_t;

   state_t                state_q;
   logic                  write_q;
   logic [2:0]            funct3_q;
   logic [1:0]            off_q;
   logic                  req_ready_q, resp_valid_q, resp_err_q;
   logic [31:0]           resp_rdata_q;
   logic                  mem_req_q, mem_we_q;
   logic [3:0]            mem_be_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [31:0]           mem_wdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
   logic                  split_q;
   logic [3:0]            hi_be_q;
   logic [31:0]           hi_wdata_q;
   logic [31:0]           lo_word_q;
   logic [7:0]            be8_d;
   logic [31:0]           wsize_d;
   logic [63:0]           wdata64_d;
`endif

   logic [1:0]            size_d;
   logic                  illegal_d, misal_d, fault_d;
   logic [3:0]            base_be_d, be_lo_d;
   logic [31:0]           wrep_d, wdata_lo_d;
   logic [ADDR_WIDTH-1:0] waddr_d;
   logic [63:0]           ld_win;
   logic [31:0]           ld_word, ld_ext;

   always_comb begin
      size_d    = req_funct3[1:0];
      illegal_d = req_write ? (req_funct3 > 3'b010)
                            : ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110));
      misal_d   = ((size_d == 2'b01) && req_addr[0]) ||
                  ((size_d == 2'b10) && (req_addr[1:0] != 2'b00));
      case (size_d)
         2'b00:   begin base_be_d = 4'b0001; wrep_d = {4{req_wdata[7:0]}};  end
         2'b01:   begin base_be_d = 4'b0011; wrep_d = {2{req_wdata[15:0]}}; end
         default: begin base_be_d = 4'b1111; wrep_d = req_wdata;            end
      endcase
      waddr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
`ifdef LSU_MISALIGN_SPLIT_EN
      // only half/word can be misaligned, so masking to 16 bits is enough
      wsize_d    = (size_d == 2'b01) ? {16'h0, req_wdata[15:0]} : req_wdata;
      be8_d      = {4'b0000, base_be_d} << req_addr[1:0];
      wdata64_d  = {32'h0, wsize_d} << {req_addr[1:0], 3'b000};
      fault_d    = illegal_d;
      be_lo_d    = be8_d[3:0];
      wdata_lo_d = misal_d ? wdata64_d[31:0] : wrep_d;
`else
      fault_d    = illegal_d || misal_d;
      be_lo_d    = base_be_d << req_addr[1:0];
      wdata_lo_d = wrep_d;
`endif
   end

   always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
      ld_win = (state_q == S_WAIT2) ? {mem_rdata, lo_word_q} : {32'h0, mem_rdata};
`else
      ld_win = {32'h0, mem_rdata};
`endif
      ld_word = 32'(ld_win >> {off_q, 3'b000});
      case (funct3_q)
         3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
         3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
         3'b100:  ld_ext = {24'h0, ld_word[7:0]};
         3'b101:  ld_ext = {16'h0, ld_word[15:0]};
         default: ld_ext = ld_word;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         write_q      <= 1'b0;
         funct3_q     <= 3'b000;
         off_q        <= 2'b00;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_be_q     <= 4'b0000;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
         split_q      <= 1'b0;
         hi_be_q      <= 4'b0000;
         hi_wdata_q   <= 32'h0;
         lo_word_q    <= 32'h0;
`endif
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  write_q     <= req_write;
                  funct3_q    <= req_funct3;
                  off_q       <= req_addr[1:0];
                  req_ready_q <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
                  split_q     <= misal_d;
                  hi_be_q     <= be8_d[7:4];
                  hi_wdata_q  <= wdata64_d[63:32];
`endif
                  if (fault_d) begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 32'h0;
                  end else begin
                     state_q     <= S_REQ;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= req_write;
                     mem_be_q    <= be_lo_d;
                     mem_addr_q  <= waddr_d;
                     mem_wdata_q <= wdata_lo_d;
                  end
               end
            end
            S_REQ: begin
               if (mem_gnt) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  if (!write_q) begin
                     state_q <= S_WAIT;
`ifdef LSU_MISALIGN_SPLIT_EN
                  end else if (split_q) begin
                     state_q     <= S_REQ2;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= 1'b1;
                     mem_be_q    <= hi_be_q;
                     mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(4);
                     mem_wdata_q <= hi_wdata_q;
`endif
                  end else begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b0;
                     resp_rdata_q <= 32'h0;
                  end
               end
            end
            S_WAIT: begin
               if (mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                  if (split_q) begin
                     state_q    <= S_REQ2;
                     lo_word_q  <= mem_rdata;
                     mem_req_q  <= 1'b1;
                     mem_we_q   <= 1'b0;
                     mem_be_q   <= hi_be_q;
                     mem_addr_q <= mem_addr_q + ADDR_WIDTH'(4);
                  end else begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b0;
                     resp_rdata_q <= ld_ext;
                  end
`else
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= ld_ext;
`endif
               end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            S_REQ2: begin
               if (mem_gnt) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  if (!write_q) begin
                     state_q <= S_WAIT2;
                  end else begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b0;
                     resp_rdata_q <= 32'h0;
                  end
               end
            end
            S_WAIT2: begin
               if (mem_rvalid) begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= ld_ext;
               end
            end
`endif
            S_RESP: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_be     = mem_be_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus hand-written multi-cycle sequences.
// Honours LSU_MISALIGN_SPLIT_EN for the misaligned-access expectations.

module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_req, mem_gnt, mem_we, mem_rvalid;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   load_store_unit #(.ADDR_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrdata;
      logic        mem;
      logic [3:0]  be;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t  vecs[$];
   int    n_tests = 0;
   int    n_fail = 0;
   string ctx = "init";

   function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] mrdata, input logic mem,
                               input logic [3:0] be, input logic [31:0] maddr,
                               input logic [31:0] mwdata, input logic [31:0] rdata, input logic err);
      vec_t v;
      v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.mrdata = mrdata;
      v.mem = mem; v.be = be; v.maddr = maddr; v.mwdata = mwdata; v.rdata = rdata; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %h expected %h", ctx, name, act, exp);
      end
   endtask

   task automatic idle_drive();
      req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
   endtask

   task automatic check_reset_vals();
      chk("ready", 32'(req_ready), 32'h1);
      chk("resp_valid", 32'(resp_valid), 32'h0);
      chk("resp_rdata", resp_rdata, 32'h0);
      chk("resp_err", 32'(resp_err), 32'h0);
      chk("mem_req", 32'(mem_req), 32'h0);
      chk("mem_we", 32'(mem_we), 32'h0);
      chk("mem_be", 32'(mem_be), 32'h0);
      chk("mem_addr", mem_addr, 32'h0);
      chk("mem_wdata", mem_wdata, 32'h0);
   endtask

   task automatic drive_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata);
      req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      chk("ready", 32'(req_ready), 32'h1);
      drive_req(v.wr, v.f3, v.addr, v.wdata);
      @(negedge clk);
      // perturb the request bus after accept; the unit must use captured fields
      req_valid = 1'b0; req_write = ~v.wr; req_funct3 = 3'b010;
      req_addr = ~v.addr; req_wdata = ~v.wdata;
      chk("ready_busy", 32'(req_ready), 32'h0);
      if (v.mem) begin
         chk("mem_req", 32'(mem_req), 32'h1);
         chk("mem_we", 32'(mem_we), 32'(v.wr));
         chk("mem_be", 32'(mem_be), 32'(v.be));
         chk("mem_addr", mem_addr, v.maddr);
         if (v.wr) chk("mem_wdata", mem_wdata, v.mwdata);
         chk("early_resp", 32'(resp_valid), 32'h0);
         mem_gnt = 1'b1;
         @(negedge clk);
         mem_gnt = 1'b0;
         chk("mem_req_drop", 32'(mem_req), 32'h0);
         if (!v.wr) begin
            chk("early_resp", 32'(resp_valid), 32'h0);
            mem_rvalid = 1'b1; mem_rdata = v.mrdata;
            @(negedge clk);
            mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_0000;
         end
      end else begin
         chk("no_mem_req", 32'(mem_req), 32'h0);
      end
      chk("resp_valid", 32'(resp_valid), 32'h1);
      chk("resp_err", 32'(resp_err), 32'(v.err));
      chk("resp_rdata", resp_rdata, v.rdata);
      @(negedge clk);
      chk("resp_pulse", 32'(resp_valid), 32'h0);
      chk("ready_after", 32'(req_ready), 32'h1);
      chk("mem_req_idle", 32'(mem_req), 32'h0);
      idle_drive();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      idle_drive();

      vecs.push_back(mk(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 1'b1, 4'b1000, 32'h100, 32'hA5A5_A5A5, 32'h0, 1'b0));
      vecs.push_back(mk(1'b1, 3'b000, 32'h040, 32'hFFFF_FF5A, 32'h0, 1'b1, 4'b0001, 32'h040, 32'h5A5A_5A5A, 32'h0, 1'b0));
      vecs.push_back(mk(1'b1, 3'b001, 32'h012, 32'h0000_BEEF, 32'h0, 1'b1, 4'b1100, 32'h010, 32'hBEEF_BEEF, 32'h0, 1'b0));
      vecs.push_back(mk(1'b1, 3'b010, 32'h020, 32'h1234_5678, 32'h0, 1'b1, 4'b1111, 32'h020, 32'h1234_5678, 32'h0, 1'b0));
      vecs.push_back(mk(1'b0, 3'b001, 32'h202, 32'h0, 32'h8001_1234, 1'b1, 4'b1100, 32'h200, 32'h0, 32'hFFFF_8001, 1'b0));
      vecs.push_back(mk(1'b0, 3'b101, 32'h202, 32'h0, 32'h8001_1234, 1'b1, 4'b1100, 32'h200, 32'h0, 32'h0000_8001, 1'b0));
      vecs.push_back(mk(1'b0, 3'b001, 32'h200, 32'h0, 32'h8001_9234, 1'b1, 4'b0011, 32'h200, 32'h0, 32'hFFFF_9234, 1'b0));
      vecs.push_back(mk(1'b0, 3'b101, 32'h200, 32'h0, 32'h8001_9234, 1'b1, 4'b0011, 32'h200, 32'h0, 32'h0000_9234, 1'b0));
      vecs.push_back(mk(1'b0, 3'b000, 32'h201, 32'h0, 32'h8001_1234, 1'b1, 4'b0010, 32'h200, 32'h0, 32'h0000_0012, 1'b0));
      vecs.push_back(mk(1'b0, 3'b000, 32'h203, 32'h0, 32'h8001_1234, 1'b1, 4'b1000, 32'h200, 32'h0, 32'hFFFF_FF80, 1'b0));
      vecs.push_back(mk(1'b0, 3'b100, 32'h203, 32'h0, 32'h8001_1234, 1'b1, 4'b1000, 32'h200, 32'h0, 32'h0000_0080, 1'b0));
      vecs.push_back(mk(1'b0, 3'b000, 32'h200, 32'h0, 32'h8001_127F, 1'b1, 4'b0001, 32'h200, 32'h0, 32'h0000_007F, 1'b0));
      vecs.push_back(mk(1'b0, 3'b010, 32'h300, 32'h0, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'h300, 32'h0, 32'hDEAD_BEEF, 1'b0));
      vecs.push_back(mk(1'b0, 3'b011, 32'h040, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1));
      vecs.push_back(mk(1'b0, 3'b110, 32'h040, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1));
      vecs.push_back(mk(1'b0, 3'b111, 32'h040, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1));
      vecs.push_back(mk(1'b1, 3'b100, 32'h040, 32'h1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1));
      vecs.push_back(mk(1'b1, 3'b011, 32'h040, 32'h1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1));
`ifndef LSU_MISALIGN_SPLIT_EN
      vecs.push_back(mk(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1));
      vecs.push_back(mk(1'b1, 3'b001, 32'h013, 32'h0000_BEEF, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1));
      vecs.push_back(mk(1'b0, 3'b101, 32'h201, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1));
      vecs.push_back(mk(1'b1, 3'b010, 32'h022, 32'h1234_5678, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1));
`endif

      // reset values
      ctx = "reset";
      repeat (2) @(negedge clk);
      check_reset_vals();
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_vals();

      foreach (vecs[i]) begin
         ctx = $sformatf("vec%0d", i);
         run_vec(vecs[i]);
      end

      // grant stalled 5 cycles, read data 3 cycles after grant
      ctx = "stall";
      @(negedge clk);
      drive_req(1'b0, 3'b010, 32'h400, 32'h0);
      @(negedge clk);
      req_valid = 1'b0; req_addr = 32'h0;
      for (int i = 0; i < 5; i++) begin
         chk("mem_req", 32'(mem_req), 32'h1);
         chk("mem_addr", mem_addr, 32'h400);
         chk("mem_be", 32'(mem_be), 32'hF);
         chk("mem_we", 32'(mem_we), 32'h0);
         @(negedge clk);
      end
      chk("mem_req_g", 32'(mem_req), 32'h1);
      chk("mem_addr_g", mem_addr, 32'h400);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      chk("mem_req_drop", 32'(mem_req), 32'h0);
      for (int i = 0; i < 2; i++) begin
         chk("early_resp", 32'(resp_valid), 32'h0);
         @(negedge clk);
      end
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      chk("resp_valid", 32'(resp_valid), 32'h1);
      chk("resp_rdata", resp_rdata, 32'hCAFE_F00D);
      chk("resp_err", 32'(resp_err), 32'h0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (resp_valid) pulses++;
      end
      chk("extra_pulses", pulses, 0);

      // reset while waiting for read data, then a stray rvalid
      ctx = "rst_wait";
      @(negedge clk);
      drive_req(1'b0, 3'b010, 32'h500, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      chk("mem_req", 32'(mem_req), 32'h1);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      chk("in_wait_ready", 32'(req_ready), 32'h0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_reset_vals();
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      mem_rvalid = 1'b0;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         if (resp_valid) pulses++;
         @(negedge clk);
      end
      chk("stray_pulses", pulses, 0);
      check_reset_vals();

      // request presented during the response cycle waits one cycle
      ctx = "b2b";
      drive_req(1'b1, 3'b010, 32'h600, 32'h1);
      @(negedge clk);
      req_valid = 1'b0;
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      chk("resp_valid", 32'(resp_valid), 32'h1);
      chk("ready_in_resp", 32'(req_ready), 32'h0);
      drive_req(1'b0, 3'b011, 32'h44, 32'h0);
      @(negedge clk);
      chk("resp_gap", 32'(resp_valid), 32'h0);
      chk("ready_idle", 32'(req_ready), 32'h1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("resp2_valid", 32'(resp_valid), 32'h1);
      chk("resp2_err", 32'(resp_err), 32'h1);
      chk("resp2_rdata", resp_rdata, 32'h0);
      chk("resp2_no_mem", 32'(mem_req), 32'h0);
      @(negedge clk);
      chk("ready_end", 32'(req_ready), 32'h1);
      idle_drive();

`ifdef LSU_MISALIGN_SPLIT_EN
      // split misaligned word load across two words
      ctx = "split_lw";
      @(negedge clk);
      drive_req(1'b0, 3'b010, 32'h101, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      chk("a1_req", 32'(mem_req), 32'h1);
      chk("a1_addr", mem_addr, 32'h100);
      chk("a1_be", 32'(mem_be), 32'hE);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h4433_2211;
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("a2_req", 32'(mem_req), 32'h1);
      chk("a2_addr", mem_addr, 32'h104);
      chk("a2_be", 32'(mem_be), 32'h1);
      chk("a2_no_resp", 32'(resp_valid), 32'h0);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h8877_6655;
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("resp_valid", 32'(resp_valid), 32'h1);
      chk("resp_rdata", resp_rdata, 32'h5544_3322);
      chk("resp_err", 32'(resp_err), 32'h0);
      @(negedge clk);
      chk("ready_end", 32'(req_ready), 32'h1);
      idle_drive();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
